// File: rtl/rggen_register_request_bridge.sv
// rggen_register_request_bridge
//   Front end of a register block. It accepts one host request at a time,
//   broadcasts it to every register instance, gathers their replies and
//   holds a single registered response until the host takes it.
//   Out-of-window addresses, unmapped addresses and stalled registers are
//   all answered with error responses, so the host can never hang.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req_*/o_req_ready   host request channel (valid/ready)
//   o_rsp_*/i_rsp_ready   host response channel (valid/ready)
//   o_reg_*               latched command broadcast to the registers
//   i_reg_*               per-register active/ready/status/read_data
//
// Sub-module rggen_register_request_bridge_lane masks one register's reply
// by its active bit; the top OR-reduces the lanes.

module rggen_register_request_bridge_lane #(
  parameter int BUS_WIDTH = 32
)(
  input  logic                 active,
  input  logic                 ready,
  input  logic [1:0]           status,
  input  logic [BUS_WIDTH-1:0] read_data,
  output logic                 hit,
  output logic [1:0]           status_m,
  output logic [BUS_WIDTH-1:0] read_data_m
);
  assign hit         = active & ready;
  assign status_m    = active ? status    : '0;
  assign read_data_m = active ? read_data : '0;
endmodule

module rggen_register_request_bridge #(
  parameter int                       ADDRESS_WIDTH       = 16,
  parameter int                       LOCAL_ADDRESS_WIDTH = 8,
  parameter int                       BUS_WIDTH           = 32,
  parameter int                       REGISTERS           = 1,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS        = '0,
  parameter int                       BYTE_SIZE           = 256,
  parameter logic [BUS_WIDTH-1:0]     DEFAULT_READ_DATA   = '0,
  parameter int                       TIMEOUT_CYCLES      = 0
)(
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_req_valid,
  output logic                             o_req_ready,
  input  logic [1:0]                       i_req_access,
  input  logic [ADDRESS_WIDTH-1:0]         i_req_address,
  input  logic [BUS_WIDTH-1:0]             i_req_write_data,
  input  logic [BUS_WIDTH/8-1:0]           i_req_strobe,
  output logic                             o_rsp_valid,
  input  logic                             i_rsp_ready,
  output logic [1:0]                       o_rsp_status,
  output logic [BUS_WIDTH-1:0]             o_rsp_read_data,
  output logic                             o_reg_valid,
  output logic [1:0]                       o_reg_access,
  output logic [LOCAL_ADDRESS_WIDTH-1:0]   o_reg_address,
  output logic [BUS_WIDTH-1:0]             o_reg_write_data,
  output logic [BUS_WIDTH/8-1:0]           o_reg_strobe,
  input  logic [REGISTERS-1:0]             i_reg_active,
  input  logic [REGISTERS-1:0]             i_reg_ready,
  input  logic [2*REGISTERS-1:0]           i_reg_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0]   i_reg_read_data
);
  localparam int RGGEN_ACCESS_DATA_BIT = 1;
  localparam logic [1:0] ST_OKAY         = 2'b00;
  localparam logic [1:0] ST_SLAVE_ERROR  = 2'b10;
  localparam logic [1:0] ST_DECODE_ERROR = 2'b11;

  localparam int LSB   = $clog2(BUS_WIDTH / 8);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [LOCAL_ADDRESS_WIDTH-1:0] ADDR_MASK =
    ~LOCAL_ADDRESS_WIDTH'((1 << LSB) - 1);
  // One extra bit so a window ending at the top of the space cannot wrap.
  localparam logic [ADDRESS_WIDTH:0] WIN_START = {1'b0, BASE_ADDRESS};
  localparam logic [ADDRESS_WIDTH:0] WIN_END   =
    WIN_START + (ADDRESS_WIDTH+1)'(BYTE_SIZE);

  typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_e;
  state_e state, state_nxt;

  logic [CNT_W-1:0] timer;
  logic             in_range, timeout, any_active, any_hit;
  logic [LOCAL_ADDRESS_WIDTH-1:0] req_local;
  logic [ADDRESS_WIDTH:0]         addr_ext;

  logic [REGISTERS-1:0]                lane_hit;
  logic [REGISTERS-1:0][1:0]           lane_status;
  logic [REGISTERS-1:0][BUS_WIDTH-1:0] lane_data;
  logic [1:0]                          sum_status;
  logic [BUS_WIDTH-1:0]                sum_data;

  assign addr_ext  = {1'b0, i_req_address};
  assign in_range  = (addr_ext >= WIN_START) && (addr_ext < WIN_END);
  assign req_local = LOCAL_ADDRESS_WIDTH'(i_req_address - BASE_ADDRESS) & ADDR_MASK;
  assign timeout   = (TIMEOUT_CYCLES != 0) && (timer == CNT_W'(TIMEOUT_CYCLES - 1));

  for (genvar g = 0; g < REGISTERS; g++) begin : g_lane
    rggen_register_request_bridge_lane #(.BUS_WIDTH(BUS_WIDTH)) u_lane (
      .active      (i_reg_active[g]),
      .ready       (i_reg_ready[g]),
      .status      (i_reg_status[2*g+:2]),
      .read_data   (i_reg_read_data[BUS_WIDTH*g+:BUS_WIDTH]),
      .hit         (lane_hit[g]),
      .status_m    (lane_status[g]),
      .read_data_m (lane_data[g])
    );
  end

  // Only one active lane is legal; OR keeps a single-driver merge either way.
  always_comb begin
    any_active = |i_reg_active;
    any_hit    = |lane_hit;
    sum_status = '0;
    sum_data   = '0;
    for (int k = 0; k < REGISTERS; k++) begin
      sum_status = sum_status | lane_status[k];
      sum_data   = sum_data   | lane_data[k];
    end
  end

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_req_valid) state_nxt = in_range ? BUSY : RESPOND;
      BUSY:    if (!any_active || any_hit || timeout) state_nxt = RESPOND;
      RESPOND: if (i_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    o_req_ready = (state == IDLE);
    o_reg_valid = (state == BUSY);
    o_rsp_valid = (state == RESPOND);
  end

  // command latch, response capture, timeout counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_reg_access     <= '0;
      o_reg_address    <= '0;
      o_reg_write_data <= '0;
      o_reg_strobe     <= '0;
      o_rsp_status     <= ST_OKAY;
      o_rsp_read_data  <= '0;
      timer            <= '0;
    end else begin
      case (state)
        IDLE: if (i_req_valid) begin
          o_reg_access  <= i_req_access;
          o_reg_address <= req_local;
          if (i_req_access[RGGEN_ACCESS_DATA_BIT]) begin
            o_reg_write_data <= i_req_write_data;
            o_reg_strobe     <= i_req_strobe;
          end else begin
            o_reg_write_data <= '0;
            o_reg_strobe     <= '1;
          end
          if (!in_range) begin
            o_rsp_status    <= ST_DECODE_ERROR;
            o_rsp_read_data <= DEFAULT_READ_DATA;
          end
        end
        BUSY: begin
          if (!any_active) begin
            o_rsp_status    <= ST_DECODE_ERROR;
            o_rsp_read_data <= DEFAULT_READ_DATA;
          end else if (any_hit) begin
            o_rsp_status    <= sum_status;
            o_rsp_read_data <= o_reg_access[RGGEN_ACCESS_DATA_BIT] ? '0 : sum_data;
          end else if (timeout) begin
            o_rsp_status    <= ST_SLAVE_ERROR;
            o_rsp_read_data <= DEFAULT_READ_DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESPOND: if (i_rsp_ready) timer <= '0;
        default: ;
      endcase
    end
  end

`ifdef RGGEN_ENABLE_SVA
  ap_single_active: assert property (@(posedge i_clk) disable iff (i_rst)
    o_reg_valid |-> $onehot0(i_reg_active));
`endif

endmodule

// File: tb/tb_rggen_register_request_bridge.sv
module tb_rggen_register_request_bridge;
  localparam int          AW    = 16;
  localparam int          LW    = 8;
  localparam int          BW    = 32;
  localparam int          NR    = 4;
  localparam int          BYTES = 256;
  localparam int          TO    = 4;
  localparam logic [15:0] BASE  = 16'h1000;
  localparam logic [31:0] DEF   = 32'hA5A5_0F0F;
  localparam int          NEVER = 1000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_req_valid = 1'b0;
  logic              o_req_ready;
  logic [1:0]        i_req_access = '0;
  logic [AW-1:0]     i_req_address = '0;
  logic [BW-1:0]     i_req_write_data = '0;
  logic [BW/8-1:0]   i_req_strobe = '0;
  logic              o_rsp_valid;
  logic              i_rsp_ready = 1'b0;
  logic [1:0]        o_rsp_status;
  logic [BW-1:0]     o_rsp_read_data;
  logic              o_reg_valid;
  logic [1:0]        o_reg_access;
  logic [LW-1:0]     o_reg_address;
  logic [BW-1:0]     o_reg_write_data;
  logic [BW/8-1:0]   o_reg_strobe;
  logic [NR-1:0]     i_reg_active = '0;
  logic [NR-1:0]     i_reg_ready = '0;
  logic [2*NR-1:0]   i_reg_status = '0;
  logic [BW*NR-1:0]  i_reg_read_data = '0;

  rggen_register_request_bridge #(
    .ADDRESS_WIDTH(AW), .LOCAL_ADDRESS_WIDTH(LW), .BUS_WIDTH(BW),
    .REGISTERS(NR), .BASE_ADDRESS(BASE), .BYTE_SIZE(BYTES),
    .DEFAULT_READ_DATA(DEF), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_access(i_req_access), .i_req_address(i_req_address),
    .i_req_write_data(i_req_write_data), .i_req_strobe(i_req_strobe),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_status(o_rsp_status), .o_rsp_read_data(o_rsp_read_data),
    .o_reg_valid(o_reg_valid), .o_reg_access(o_reg_access),
    .o_reg_address(o_reg_address), .o_reg_write_data(o_reg_write_data),
    .o_reg_strobe(o_reg_strobe),
    .i_reg_active(i_reg_active), .i_reg_ready(i_reg_ready),
    .i_reg_status(i_reg_status), .i_reg_read_data(i_reg_read_data)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // expectations produced by the transaction model
  logic        chk_en = 1'b0;
  logic        exp_req_ready = 1'b1, exp_reg_valid = 1'b0, exp_rsp_valid = 1'b0;
  logic [1:0]  exp_access = '0, exp_status = '0;
  logic [7:0]  exp_addr = '0;
  logic [31:0] exp_wdata = '0, exp_rdata = '0;
  logic [3:0]  exp_strobe = '0;

  // observations used by the literal checks
  int          cyc = 0, acc_cyc = 0, rsp_cyc = 0, busy_cnt = 0;
  logic        rsp_seen = 1'b0;
  logic [1:0]  m_status = '0;
  logic [31:0] m_rdata = '0;
  logic [7:0]  m_addr = '0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      cmp("req_ready", 32'(o_req_ready), 32'(exp_req_ready));
      cmp("reg_valid", 32'(o_reg_valid), 32'(exp_reg_valid));
      cmp("rsp_valid", 32'(o_rsp_valid), 32'(exp_rsp_valid));
      if (exp_reg_valid) begin
        cmp("reg_access",  32'(o_reg_access),  32'(exp_access));
        cmp("reg_address", 32'(o_reg_address), 32'(exp_addr));
        cmp("reg_wdata",   o_reg_write_data,   exp_wdata);
        cmp("reg_strobe",  32'(o_reg_strobe),  32'(exp_strobe));
      end
      if (exp_rsp_valid) begin
        cmp("rsp_status", 32'(o_rsp_status), 32'(exp_status));
        cmp("rsp_rdata",  o_rsp_read_data,   exp_rdata);
      end
    end
    if (!rst && o_req_ready && i_req_valid) begin
      acc_cyc = cyc; busy_cnt = 0; rsp_seen = 1'b0;
    end
    if (o_reg_valid) begin busy_cnt++; m_addr = o_reg_address; end
    if (o_rsp_valid && !rsp_seen) begin
      rsp_seen = 1'b1; rsp_cyc = cyc; m_status = o_rsp_status; m_rdata = o_rsp_read_data;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic noise_regs();
    i_reg_active    = 4'($urandom);
    i_reg_ready     = 4'($urandom);
    i_reg_status    = 8'($urandom);
    i_reg_read_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Inactive registers get random replies; only the active one should matter.
  task automatic drive_regs(input int act, input logic rdy, input logic [1:0] st, input logic [31:0] rd);
    i_reg_ready     = 4'($urandom);
    i_reg_status    = 8'($urandom);
    i_reg_read_data = {$urandom, $urandom, $urandom, $urandom};
    i_reg_active    = '0;
    if (act >= 0) begin
      i_reg_active[act]           = 1'b1;
      i_reg_ready[act]            = rdy;
      i_reg_status[act*2 +: 2]    = st;
      i_reg_read_data[act*32 +: 32] = rd;
    end
  endtask

  task automatic rand_req();
    i_req_valid      = 1'b1;
    i_req_access     = 2'($urandom);
    i_req_address    = 16'($urandom);
    i_req_write_data = $urandom;
    i_req_strobe     = 4'($urandom);
  endtask

  // One whole transaction: the model decides how many broadcast cycles the
  // request lasts and what the response must be, then the driver walks that
  // timeline cycle by cycle while the compare process checks every cycle.
  task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                         input logic [3:0] strb, input int act, input int d,
                         input logic [1:0] st, input logic [31:0] rd, input int hold);
    int a, nb;
    logic [1:0] es, acc;
    logic [31:0] ed;
    logic in_rng;
    a = int'(addr);
    in_rng = (a >= int'(BASE)) && (a < int'(BASE) + BYTES);
    if (!in_rng)       begin nb = 0;     es = 2'b11; ed = DEF; end
    else if (act < 0)  begin nb = 1;     es = 2'b11; ed = DEF; end
    else if (d < TO)   begin nb = d + 1; es = st;    ed = wr ? 32'h0 : rd; end
    else               begin nb = TO;    es = 2'b10; ed = DEF; end
    acc = {wr, 1'($urandom)};

    exp_req_ready = 1'b1; exp_reg_valid = 1'b0; exp_rsp_valid = 1'b0;
    i_req_valid = 1'b1; i_req_access = acc; i_req_address = addr;
    i_req_write_data = wd; i_req_strobe = strb;
    noise_regs(); i_rsp_ready = 1'($urandom);
    step();

    exp_access = acc;
    exp_addr   = in_rng ? 8'(((a - int'(BASE)) % 256) / 4 * 4) : 8'h00;
    exp_wdata  = wr ? wd : 32'h0;
    exp_strobe = wr ? strb : 4'hF;
    exp_status = es;
    exp_rdata  = ed;
    for (int i = 0; i < nb; i++) begin
      exp_req_ready = 1'b0; exp_reg_valid = 1'b1; exp_rsp_valid = 1'b0;
      rand_req(); drive_regs(act, (i == d), st, rd); i_rsp_ready = 1'($urandom);
      step();
    end
    for (int h = 0; h <= hold; h++) begin
      exp_req_ready = 1'b0; exp_reg_valid = 1'b0; exp_rsp_valid = 1'b1;
      rand_req(); noise_regs(); i_rsp_ready = (h == hold);
      step();
    end
    i_req_valid = 1'b0; i_rsp_ready = 1'b0;
    exp_req_ready = 1'b1; exp_reg_valid = 1'b0; exp_rsp_valid = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    cmp({tag, "_req_ready"}, 32'(o_req_ready),      32'd1);
    cmp({tag, "_reg_valid"}, 32'(o_reg_valid),      32'd0);
    cmp({tag, "_rsp_valid"}, 32'(o_rsp_valid),      32'd0);
    cmp({tag, "_status"},    32'(o_rsp_status),     32'd0);
    cmp({tag, "_rdata"},     o_rsp_read_data,       32'd0);
    cmp({tag, "_access"},    32'(o_reg_access),     32'd0);
    cmp({tag, "_address"},   32'(o_reg_address),    32'd0);
    cmp({tag, "_wdata"},     o_reg_write_data,      32'd0);
    cmp({tag, "_strobe"},    32'(o_reg_strobe),     32'd0);
  endtask

  initial begin
    int act, d, r, hold, gap;
    logic [15:0] addr;

    step(); step();
    chk_reset("rst");
    rst = 1'b0;
    step();
    chk_en = 1'b1;
    step();

    // write, register 1 ready at once
    run_txn(1'b1, BASE + 16'h4, 32'h1234_5678, 4'hF, 1, 0, 2'b00, 32'h5555_AAAA, 0);
    cmp("w_busy_cycles", 32'(busy_cnt), 32'd1);
    cmp("w_local_addr",  32'(m_addr),   32'h04);
    cmp("w_latency",     32'(rsp_cyc - acc_cyc), 32'd2);
    cmp("w_rdata",       m_rdata,       32'h0);
    cmp("w_status",      32'(m_status), 32'd0);
    step();

    // read, register 2 ready after 3 broadcast cycles
    run_txn(1'b0, BASE + 16'h8, 32'hFFFF_FFFF, 4'h1, 2, 2, 2'b00, 32'hDEAD_BEEF, 0);
    cmp("r_busy_cycles", 32'(busy_cnt), 32'd3);
    cmp("r_rdata",       m_rdata,       32'hDEAD_BEEF);

    // first address past the window
    run_txn(1'b0, BASE + 16'(BYTES), 32'h0, 4'h0, 0, 0, 2'b00, 32'h1, 0);
    cmp("oor_busy_cycles", 32'(busy_cnt), 32'd0);
    cmp("oor_status",      32'(m_status), 32'd3);
    cmp("oor_rdata",       m_rdata,       32'hA5A5_0F0F);

    // address just below the window
    run_txn(1'b0, BASE - 16'h1, 32'h0, 4'h0, 0, 0, 2'b00, 32'h1, 1);
    cmp("below_busy_cycles", 32'(busy_cnt), 32'd0);

    // last word of the window, unaligned
    run_txn(1'b0, BASE + 16'h0FF, 32'h0, 4'h0, 3, 1, 2'b01, 32'h0BAD_F00D, 0);
    cmp("top_local_addr", 32'(m_addr), 32'hFC);

    // in range but nothing decodes it
    run_txn(1'b0, BASE + 16'h10, 32'h0, 4'h0, -1, 0, 2'b00, 32'h0, 0);
    cmp("unmapped_busy_cycles", 32'(busy_cnt), 32'd1);
    cmp("unmapped_status",      32'(m_status), 32'd3);

    // register never ready -> timeout; host stalls the response 5 cycles
    run_txn(1'b0, BASE + 16'h20, 32'h0, 4'h0, 0, NEVER, 2'b00, 32'h0, 5);
    cmp("to_busy_cycles", 32'(busy_cnt), 32'd4);
    cmp("to_status",      32'(m_status), 32'd2);
    cmp("to_rdata",       m_rdata,       32'hA5A5_0F0F);

    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      addr = 16'($urandom_range(32'h0F00, 32'h0FFF));
      else if (r == 1) addr = 16'($urandom_range(32'h1100, 32'h11FF));
      else             addr = 16'($urandom_range(32'h1000, 32'h10FF));
      act  = int'($urandom_range(0, 4)) - 1;
      d    = int'($urandom_range(0, 6));
      if (d == 6) d = NEVER;
      hold = int'($urandom_range(0, 3));
      run_txn(1'($urandom), addr, $urandom, 4'($urandom), act, d, 2'($urandom), $urandom, hold);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) step();
    end

    // reset in the middle of a broadcast
    chk_en = 1'b0;
    i_req_valid = 1'b1; i_req_access = 2'b10; i_req_address = BASE + 16'h30;
    i_req_write_data = 32'hCAFE_0001; i_req_strobe = 4'h3;
    drive_regs(1, 1'b0, 2'b00, 32'h0);
    step();
    step();
    cmp("pre_rst_reg_valid", 32'(o_reg_valid), 32'd1);
    rst = 1'b1;
    step();
    chk_reset("midrst");
    rst = 1'b0; i_req_valid = 1'b0;
    step();
    cmp("post_rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    cmp("post_rst_req_ready", 32'(o_req_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/rggen_register_request_bridge.md
Name: rggen_register_request_bridge

Overview:
- Upstream stage of every register block: takes one host request at a time over a valid/ready channel and broadcasts it to all register instances (valid/access/address/write_data/strobe).
- Gathers their active/ready/status/read_data, then returns a single buffered response.
- Handles out-of-range addresses, unmapped addresses, and stalled registers (timeout) with error responses, so the host never hangs.

Parameters:
- ADDRESS_WIDTH, 16: host address width.
- LOCAL_ADDRESS_WIDTH, 8: width of the address driven to registers.
- BUS_WIDTH, 32: data width; must be a multiple of 8.
- REGISTERS, 1: number of register instances attached (≥1).
- BASE_ADDRESS, 0: ADDRESS_WIDTH-bit base of this block; must be BUS_WIDTH/8-aligned.
- BYTE_SIZE, 256: address window size in bytes; must be ≤ 2**LOCAL_ADDRESS_WIDTH.
- DEFAULT_READ_DATA, 0: BUS_WIDTH-bit read data returned with error responses.
- TIMEOUT_CYCLES, 0: maximum BUSY cycles without register ready; 0 disables timeout.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_req_valid  in  1  host request valid
- o_req_ready  out  1  host request accepted
- i_req_access  in  2  rggen_access encoding; bit RGGEN_ACCESS_DATA_BIT=1 means write
- i_req_address  in  ADDRESS_WIDTH  byte address
- i_req_write_data  in  BUS_WIDTH  write data
- i_req_strobe  in  BUS_WIDTH/8  byte enables
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  host response accepted
- o_rsp_status  out  2  00 OKAY, 10 SLAVE_ERROR, 11 DECODE_ERROR
- o_rsp_read_data  out  BUS_WIDTH  read data
- o_reg_valid  out  1  broadcast request valid
- o_reg_access  out  2  latched access
- o_reg_address  out  LOCAL_ADDRESS_WIDTH  latched local address
- o_reg_write_data  out  BUS_WIDTH  latched write data
- o_reg_strobe  out  BUS_WIDTH/8  latched strobe
- i_reg_active  in  REGISTERS  per-register address match
- i_reg_ready  in  REGISTERS  per-register done
- i_reg_status  in  2*REGISTERS  per-register status, register k at [2k+:2]
- i_reg_read_data  in  BUS_WIDTH*REGISTERS  per-register read data

Behaviour:
- Reset: state IDLE; o_req_ready=1; o_rsp_valid=0; o_reg_valid=0; o_rsp_status=00; o_rsp_read_data=0; all latched command fields 0; timeout counter 0. Reset mid-transaction abandons it with no response.
- FSM IDLE -> BUSY -> RESPOND -> IDLE. Exactly one outstanding request.
- IDLE: o_req_ready=1.
  - On i_req_valid, latch the command.
  - In range (BASE_ADDRESS ≤ addr < BASE_ADDRESS+BYTE_SIZE): go to BUSY.
  - Otherwise: go to RESPOND with DECODE_ERROR and DEFAULT_READ_DATA, no register access.
- Latched command, held constant through BUSY:
  - Local address = (addr − BASE_ADDRESS) truncated to LOCAL_ADDRESS_WIDTH, low log2(BUS_WIDTH/8) bits forced to 0.
  - Reads: strobe forced all-ones, write_data forced 0.
- BUSY: o_reg_valid=1, o_req_ready=0. Each cycle:
  - No active bit: go to RESPOND with DECODE_ERROR and DEFAULT_READ_DATA.
  - Else, if any (active & ready) bit: capture status and read_data as the OR over active-masked registers, then go to RESPOND. Write responses carry read_data=0.
  - Else, if TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES−1: go to RESPOND with SLAVE_ERROR and DEFAULT_READ_DATA.
  - Else: increment the counter.
  - o_reg_valid drops the cycle after completion.
- RESPOND: o_rsp_valid=1; status and data are registered and stable until i_rsp_ready. On i_rsp_ready go to IDLE and clear the counter. New requests are not accepted in RESPOND.
- Latency (ready in first BUSY cycle): accept at edge 0, o_reg_valid high in cycle 1, o_rsp_valid high in cycle 2. Minimum throughput is one transaction per 3 cycles.
- More than one active bit is illegal. Responses are OR-combined; an SVA flags it under RGGEN_ENABLE_SVA.
- Window end computed in ADDRESS_WIDTH+1 bits so no overflow when the window ends at the top of the address space.

Test Plan:
- Write 0x1234_5678, strobe 0xF, to BASE+4 with register 1 active and ready immediately -> o_reg_address=0x04 and o_reg_valid for exactly 1 cycle; response OKAY, data 0, o_rsp_valid on cycle 2.
- Read BASE+8 with register 2 active, ready after 3 cycles, data 0xDEAD_BEEF -> o_reg_valid held 3 cycles with stable command; response OKAY 0xDEAD_BEEF.
- Read BASE+BYTE_SIZE -> o_reg_valid never asserted; DECODE_ERROR, data=DEFAULT_READ_DATA.
- In-range read where no register is active -> one BUSY cycle, then DECODE_ERROR.
- TIMEOUT_CYCLES=4 with active register never ready -> o_reg_valid high exactly 4 cycles; then SLAVE_ERROR.
- i_rsp_ready held low 5 cycles with i_req_valid high -> o_rsp_valid and data stable, o_req_ready=0. Then assert i_rst mid-BUSY -> all outputs return to reset values next cycle.
